// File: rtl/tx_arb_pkg.sv
// Shared types and default sizing for the transmit frame arbiter.
// Pure declarations: no logic, no latency, no flow control.
package tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DRAIN,
    GAP
  } state_t;

  typedef logic [7:0] byte_t;

  localparam int IFG_DEFAULT     = 2;
  localparam int MAX_LEN_DEFAULT = 1518;

endpackage

// File: rtl/tx_frame_arbiter_rr_picker.sv
// Round-robin first-set search starting just after the last winner.
// Purely combinational; no state, no flow control.
module rr_picker
  import tx_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             any
);

  logic          found;
  logic [IW-1:0] cand;

  // Visit last+1 .. last+N_REQ so the previous winner is considered last.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IW'((int'(last) + i) % N_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

  assign any = found;

endmodule

// File: rtl/tx_frame_arbiter.sv
// Grants whole frames from N_REQ requesters onto one byte stream, round-robin, with an inter-frame gap.
// Accepted bytes reach txd one cycle later; req_ready depends only on state and the held grant.
module tx_frame_arbiter
  import tx_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int IFG     = IFG_DEFAULT,
  parameter int MAX_LEN = MAX_LEN_DEFAULT,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [8*N_REQ-1:0]         req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  output logic [7:0]                 txd,
  output logic                       tx_en,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       err_underrun,
  output logic                       err_len
);

  localparam int                IW          = $clog2(N_REQ);
  localparam logic [LEN_W-1:0]  LAST_CNT    = LEN_W'(MAX_LEN - 1);
  localparam logic [3:0]        GAP_END     = 4'(IFG - 1);
  localparam state_t            AFTER_FRAME = (IFG > 0) ? GAP : IDLE;

  state_t           state;
  logic [IW-1:0]    last_q;
  logic [N_REQ-1:0] gnt_oh;
  logic [LEN_W-1:0] count;
  logic [3:0]       gap_cnt;

  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  byte_t            cur_byte;
  logic             cur_valid;
  logic             cur_last;

  rr_picker #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_picker (
    .req   (req_valid),
    .last  (last_q),
    .grant (pick_oh),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign cur_valid = req_valid[grant_id];
  assign cur_last  = req_last[grant_id];
  assign cur_byte  = req_data[{grant_id, 3'b000} +: 8];

  assign req_ready = (state == SEND || state == DRAIN) ? gnt_oh : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_q       <= IW'(N_REQ - 1);
      gnt_oh       <= '0;
      grant_id     <= '0;
      count        <= '0;
      gap_cnt      <= '0;
      txd          <= '0;
      tx_en        <= 1'b0;
      err_underrun <= 1'b0;
      err_len      <= 1'b0;
    end else begin
      txd          <= '0;
      tx_en        <= 1'b0;
      err_underrun <= 1'b0;
      err_len      <= 1'b0;

      unique case (state)
        IDLE: begin
          if (pick_any) begin
            grant_id <= pick_idx;
            last_q   <= pick_idx;
            gnt_oh   <= pick_oh;
            count    <= '0;
            state    <= SEND;
          end
        end

        SEND: begin
          if (cur_valid) begin
            txd   <= cur_byte;
            tx_en <= 1'b1;
            count <= count + 1'b1;
            // A last byte landing exactly on MAX_LEN is a complete frame, not a truncation.
            if (cur_last) begin
              gap_cnt <= '0;
              state   <= AFTER_FRAME;
            end else if (count == LAST_CNT) begin
              err_len <= 1'b1;
              state   <= DRAIN;
            end
          end else begin
            err_underrun <= 1'b1;
          end
        end

        DRAIN: begin
          if (cur_valid && cur_last) begin
            gap_cnt <= '0;
            state   <= AFTER_FRAME;
          end
        end

        GAP: begin
          if (gap_cnt == GAP_END) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Scoreboard bench: main DUT (IFG=2, MAX_LEN=4) plus a second instance with IFG=0.
module tb_tx_frame_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [8*N-1:0] req_data;
  logic [7:0]     txd;
  logic           tx_en, busy, err_underrun, err_len;
  logic [1:0]     grant_id;

  logic [N-1:0]   req_valid2, req_last2, req_ready2;
  logic [8*N-1:0] req_data2;
  logic [7:0]     txd2;
  logic           tx_en2, busy2, err_underrun2, err_len2;
  logic [1:0]     grant_id2;

  tx_frame_arbiter #(.N_REQ(4), .IFG(2), .MAX_LEN(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .txd(txd), .tx_en(tx_en),
    .grant_id(grant_id), .busy(busy), .err_underrun(err_underrun), .err_len(err_len)
  );

  tx_frame_arbiter #(.N_REQ(4), .IFG(0), .MAX_LEN(1518)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_data(req_data2),
    .req_last(req_last2), .req_ready(req_ready2), .txd(txd2), .tx_en(tx_en2),
    .grant_id(grant_id2), .busy(busy2), .err_underrun(err_underrun2), .err_len(err_len2)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-port frame memory: {stall cycles before this byte, last, data}
  logic [11:0] fmem [N][64];
  int head [N];
  int tail [N];
  int wait_c [N];
  bit loaded [N];

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] dat;
    logic       elen;
  } exp_t;

  exp_t       exq [$];
  logic [8:0] exq2 [$];
  int         start2 = 1 << 30;
  int         log_cyc [128];
  int         n_log   = 0;
  int         und_cnt = 0;
  bit         mon_on  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int p, input int d, input bit l, input int st);
    fmem[p][tail[p]] = {3'(st), l, 8'(d)};
    tail[p]++;
  endtask

  task automatic expect_b(input int id, input int d, input bit elen);
    exq.push_back({2'(id), 8'(d), elen});
  endtask

  function automatic bit pending();
    bit r = 1'b0;
    for (int p = 0; p < N; p++) if (head[p] < tail[p]) r = 1'b1;
    return r;
  endfunction

  task automatic wait_done(input string name);
    int k = 0;
    do begin
      @(negedge clk); #2;
      k++;
    end while (k < 300 && (exq.size() != 0 || busy || pending()));
    check(name, {31'd0, (exq.size() == 0 && !busy && !pending())}, 32'd1);
  endtask

  // Requester model: presents queued bytes, advances on handshake, drops everything on reset.
  initial begin : driver
    logic [N-1:0] acc;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int p = 0; p < N; p++) begin
      head[p] = 0; wait_c[p] = 0; loaded[p] = 1'b0;
    end
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      for (int p = 0; p < N; p++) begin
        if (acc[p]) begin head[p]++; loaded[p] = 1'b0; end
        if (rst) begin head[p] = tail[p]; loaded[p] = 1'b0; wait_c[p] = 0; end
        if (head[p] < tail[p] && !loaded[p]) begin
          wait_c[p] = int'(fmem[p][head[p]][11:9]);
          loaded[p] = 1'b1;
        end
        if (head[p] < tail[p] && wait_c[p] == 0) begin
          req_valid[p]        = 1'b1;
          req_last[p]         = fmem[p][head[p]][8];
          req_data[8*p +: 8]  = fmem[p][head[p]][7:0];
        end else begin
          req_valid[p]        = 1'b0;
          req_last[p]         = 1'b0;
          req_data[8*p +: 8]  = 8'h00;
          if (wait_c[p] > 0) wait_c[p]--;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (err_underrun) und_cnt++;
        n_chk++;
        if (tx_en) begin
          if (exq.size() == 0) begin
            n_fail++;
            $display("FAIL sb_extra: got byte %h port %0d, expected no output", txd, grant_id);
          end else begin
            e = exq.pop_front();
            if ({grant_id, txd, err_len} !== {e.id, e.dat, e.elen}) begin
              n_fail++;
              $display("FAIL sb_byte: got port %0d byte %h err_len %b, expected port %0d byte %h err_len %b",
                       grant_id, txd, err_len, e.id, e.dat, e.elen);
            end
          end
          if (n_log < 128) begin log_cyc[n_log] = cyc; n_log++; end
        end else if (err_len || txd != 8'h00) begin
          n_fail++;
          $display("FAIL idle_out: got txd %h err_len %b with tx_en low, expected 00 0", txd, err_len);
        end
      end
    end
  end

  initial begin : monitor2
    logic [8:0] e2;
    forever begin
      @(negedge clk);
      if (cyc >= start2 && exq2.size() > 0) begin
        e2 = exq2.pop_front();
        n_chk++;
        if ({tx_en2, txd2} !== e2) begin
          n_fail++;
          $display("FAIL ifg0_cycle: got tx_en %b txd %h, expected tx_en %b txd %h",
                   tx_en2, txd2, e2[8], e2[7:0]);
        end
      end
    end
  end

  initial begin : main
    int b, t0, u0, k, idx;
    int ports [3];
    logic [7:0] bytes6 [3];
    bit acc2;
    ports  = '{0, 1, 3};
    bytes6 = '{8'h31, 8'h32, 8'h33};
    rst = 1'b1;
    for (int p = 0; p < N; p++) tail[p] = 0;
    req_valid2 = '0; req_last2 = '0; req_data2 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    check("rst_tx_en", {31'd0, tx_en}, 0);
    check("rst_txd", {24'd0, txd}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_grant_id", {30'd0, grant_id}, 0);
    check("rst_req_ready", {28'd0, req_ready}, 0);
    check("rst_errs", {30'd0, err_underrun, err_len}, 0);
    check("rst_tx_en_ifg0", {31'd0, tx_en2}, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    mon_on = 1'b1;

    // Single 3-byte frame from port 2
    @(posedge clk); #2;
    t0 = cyc; b = n_log;
    add(2, 'h11, 0, 0); add(2, 'h22, 0, 0); add(2, 'h33, 1, 0);
    expect_b(2, 'h11, 0); expect_b(2, 'h22, 0); expect_b(2, 'h33, 0);
    wait_done("t1_done");
    check("t1_first_latency", log_cyc[b] - t0, 3);
    check("t1_contiguous", log_cyc[b+2] - log_cyc[b], 2);
    check("t1_underrun", und_cnt, 0);

    // Round robin across ports 0,1,3 with IFG=2, fresh pointer
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2; rst = 1'b0;
    @(posedge clk); #2;
    b = n_log;
    foreach (ports[i]) for (int f = 0; f < 2; f++) for (int j = 0; j < 2; j++)
      add(ports[i], 'hA0 + 16*ports[i] + 2*f + j, j == 1, 0);
    for (int f = 0; f < 2; f++) foreach (ports[i]) for (int j = 0; j < 2; j++)
      expect_b(ports[i], 'hA0 + 16*ports[i] + 2*f + j, 0);
    wait_done("t2_done");
    for (int g = 0; g < 5; g++)
      check($sformatf("t2_gap%0d", g), log_cyc[b+2*g+2] - log_cyc[b+2*g+1], 4);
    check("t2_underrun", und_cnt, 0);

    // Port 1 stalls two cycles before its 3rd byte; port 2 must wait
    @(posedge clk); #2;
    b = n_log; u0 = und_cnt;
    add(1, 'h41, 0, 0); add(1, 'h42, 0, 0); add(1, 'h43, 0, 2); add(1, 'h44, 1, 0);
    add(2, 'h5A, 1, 0);
    expect_b(1, 'h41, 0); expect_b(1, 'h42, 0); expect_b(1, 'h43, 0); expect_b(1, 'h44, 0);
    expect_b(2, 'h5A, 0);
    wait_done("t3_done");
    check("t3_stall_gap", log_cyc[b+2] - log_cyc[b+1], 3);
    check("t3_resume", log_cyc[b+3] - log_cyc[b+2], 1);
    check("t3_underrun_pulses", und_cnt - u0, 2);

    // 7-byte frame truncated at MAX_LEN=4, port 1 next
    @(posedge clk); #2;
    b = n_log; u0 = und_cnt;
    for (int j = 1; j <= 7; j++) add(0, 'hC0 + j, j == 7, 0);
    add(1, 'hE1, 0, 0); add(1, 'hE2, 1, 0);
    expect_b(0, 'hC1, 0); expect_b(0, 'hC2, 0); expect_b(0, 'hC3, 0); expect_b(0, 'hC4, 1);
    expect_b(1, 'hE1, 0); expect_b(1, 'hE2, 0);
    wait_done("t4_done");
    check("t4_drain_gap", log_cyc[b+4] - log_cyc[b+3], 7);
    check("t4_underrun", und_cnt - u0, 0);

    // Reset during byte 3 of a 5-byte frame
    @(posedge clk); #2;
    b = n_log;
    for (int j = 1; j <= 5; j++) add(0, 'hF0 + j, j == 5, 0);
    expect_b(0, 'hF1, 0); expect_b(0, 'hF2, 0);
    k = 0;
    do begin
      @(negedge clk); #2;
      k++;
    end while (k < 50 && n_log < b + 2);
    check("t5_two_bytes_out", n_log - b, 2);
    rst = 1'b1;
    @(negedge clk); #2;
    check("t5_rst_tx_en", {31'd0, tx_en}, 0);
    check("t5_rst_busy", {31'd0, busy}, 0);
    check("t5_rst_req_ready", {28'd0, req_ready}, 0);
    rst = 1'b0;
    @(posedge clk); #2;
    add(3, 'hD9, 1, 0);
    add(0, 'h61, 0, 0); add(0, 'h62, 1, 0);
    expect_b(0, 'h61, 0); expect_b(0, 'h62, 0); expect_b(3, 'hD9, 0);
    wait_done("t5_done");

    // IFG=0 instance: back-to-back single-byte frames from port 3
    @(posedge clk); #1;
    start2 = cyc + 2;
    for (int j = 0; j < 3; j++) begin
      exq2.push_back({1'b1, bytes6[j]});
      exq2.push_back(9'h000);
    end
    req_valid2 = 4'b1000;
    req_last2  = 4'b1000;
    req_data2  = {bytes6[0], 24'h0};
    idx = 0;
    for (int j = 0; j < 40 && idx < 3; j++) begin
      @(negedge clk);
      acc2 = req_valid2[3] & req_ready2[3];
      @(posedge clk); #1;
      if (acc2) begin
        idx++;
        if (idx < 3) req_data2 = {bytes6[idx], 24'h0};
        else begin req_valid2 = '0; req_last2 = '0; req_data2 = '0; end
      end
    end
    check("t6_frames_sent", idx, 3);
    repeat (4) @(negedge clk);
    #2;
    check("t6_sb_drained", exq2.size(), 0);
    check("t6_underrun", {31'd0, err_underrun2}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
